cfg_connection_block: RTL and testbench

- Next-generation fabric connection block. Parametrised in CLB count per channel (NCLB), track widths and carry width.
- Tracks are unidirectional in/out/oe vectors; the top level owns the tristate boundary.
- Configuration arrives on the serial cen/set_in/shift_in/shift_out chain into a staging register. set_in commits staging to an active shadow register, so reconfiguration is glitch-free.
- Routing is forced to a safe all-off state until the first commit after reset.

---
 rtl/cfg_connection_block_pkg.sv | 62 ++++++
 rtl/cfg_connection_block_if.sv | 10 +
 rtl/cfg_connection_block_shadow_reg.sv | 46 ++++
 rtl/cfg_connection_block.sv | 87 ++++++++
 tb/tb_cfg_connection_block.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_connection_block_pkg.sv
// Shared sizing and config-image layout helpers for the connection block.
// The offset functions define the bit layout and are reused by image builders.
package cfg_cb_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'd0,
    OP_SHIFT  = 2'd1,
    OP_COMMIT = 2'd2
  } cfg_op_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned f_t(input int unsigned ws, input int unsigned wd);
    return 2 * (ws + wd);
  endfunction

  function automatic int unsigned f_seli(input int unsigned t);
    return clog2(t + 1);
  endfunction

  function automatic int unsigned f_selo(input int unsigned nclb, input int unsigned clbout);
    return clog2(nclb * clbout + 1);
  endfunction

  function automatic int unsigned f_cfg_bits(input int unsigned nclb, input int unsigned t,
                                             input int unsigned selo, input int unsigned clbin,
                                             input int unsigned seli);
    return nclb + t * selo + nclb * clbin * seli;
  endfunction

  function automatic int unsigned cin_off(input int unsigned i);
    return i;
  endfunction

  function automatic int unsigned trk_off(input int unsigned nclb, input int unsigned selo,
                                          input int unsigned t);
    return nclb + t * selo;
  endfunction

  function automatic int unsigned in_off(input int unsigned nclb, input int unsigned t,
                                         input int unsigned selo, input int unsigned clbin,
                                         input int unsigned seli, input int unsigned i,
                                         input int unsigned j);
    return nclb + t * selo + (i * clbin + j) * seli;
  endfunction

  function automatic cfg_op_e decode_op(input logic cen, input logic set_in);
    if (!cen) return OP_HOLD;
    return set_in ? OP_COMMIT : OP_SHIFT;
  endfunction

endpackage

// File: rtl/cfg_connection_block_if.sv
// Serial configuration chain: clock enable, commit strobe, data in and out.
interface cfg_connection_block_if;
  logic cen;
  logic set_in;
  logic shift_in;
  logic shift_out;

  modport master (output cen, output set_in, output shift_in, input shift_out);
  modport slave  (input cen, input set_in, input shift_in, output shift_out);
endinterface

// File: rtl/cfg_connection_block_shadow_reg.sv
// Staging shift register plus active shadow copy; commit replaces the shift
// for that cycle so the active image only ever changes atomically.
module cfg_shadow_reg
  import cfg_cb_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_cen,
  input  logic         i_set,
  input  logic         i_shift,
  output logic [W-1:0] o_active,
  output logic         o_valid,
  output logic         o_shift_out
);

  logic [W-1:0] r_stage;
  logic [W-1:0] r_active;
  logic         r_valid;
  cfg_op_e      w_op;

  assign w_op = decode_op(i_cen, i_set);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stage  <= '0;
      r_active <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (w_op)
        OP_SHIFT:  r_stage <= {r_stage[W-2:0], i_shift};
        OP_COMMIT: begin
          r_active <= r_stage;
          r_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_active    = r_active;
  assign o_valid     = r_valid;
  assign o_shift_out = r_stage[W-1];

endmodule

// File: rtl/cfg_connection_block.sv
// Fabric connection block: configurable CLB-input muxes, track drivers and
// carry chain, all driven from a glitch-free shadowed configuration image.
module cfg_connection_block
  import cfg_cb_pkg::*;
#(
  parameter int unsigned WS     = 4,
  parameter int unsigned WD     = 8,
  parameter int unsigned NCLB   = 2,
  parameter int unsigned CLBIN  = 10,
  parameter int unsigned CLBOUT = 5,
  parameter int unsigned CARRY  = 1,
  localparam int unsigned T        = f_t(WS, WD),
  localparam int unsigned SELI     = f_seli(T),
  localparam int unsigned SELO     = f_selo(NCLB, CLBOUT),
  localparam int unsigned CFG_BITS = f_cfg_bits(NCLB, T, SELO, CLBIN, SELI)
) (
  input  logic                    clk,
  input  logic                    rst,
  cfg_connection_block_if.slave   cfg,
  input  logic [T-1:0]            track_in,
  output logic [T-1:0]            track_out,
  output logic [T-1:0]            track_oe,
  input  logic [NCLB*CLBOUT-1:0]  clb_output,
  input  logic [NCLB*CARRY-1:0]   clb_cout,
  output logic [NCLB*CLBIN-1:0]   clb_input,
  output logic [NCLB*CARRY-1:0]   clb_cin,
  input  logic [CARRY-1:0]        carry_in,
  output logic [CARRY-1:0]        carry_out,
  output logic                    cfg_valid
);

  localparam int unsigned     NOUT     = NCLB * CLBOUT;
  localparam logic [SELO-1:0] NOUT_SEL = SELO'(NOUT);

  logic [CFG_BITS-1:0]    w_active;
  logic                   w_valid;
  logic [(1<<SELO)-1:0]   w_out_tbl;
  logic [(1<<SELI)-1:0]   w_in_tbl;

  cfg_shadow_reg #(.W(CFG_BITS)) u_shadow (
    .clk         (clk),
    .rst         (rst),
    .i_cen       (cfg.cen),
    .i_set       (cfg.set_in),
    .i_shift     (cfg.shift_in),
    .o_active    (w_active),
    .o_valid     (w_valid),
    .o_shift_out (cfg.shift_out)
  );

  // Select 0 and out-of-range selects both land on zero-filled table entries.
  always_comb begin
    w_out_tbl = '0;
    w_out_tbl[NOUT:1] = clb_output;
    w_in_tbl = '0;
    w_in_tbl[T:1] = track_in;
  end

  for (genvar t = 0; t < T; t++) begin : g_trk
    logic [SELO-1:0] w_sel;
    assign w_sel        = w_active[trk_off(NCLB, SELO, t) +: SELO];
    assign track_oe[t]  = w_valid & (w_sel != '0) & (w_sel <= NOUT_SEL);
    assign track_out[t] = w_valid & w_out_tbl[w_sel];
  end

  for (genvar i = 0; i < NCLB; i++) begin : g_clb
    for (genvar j = 0; j < CLBIN; j++) begin : g_pin
      logic [SELI-1:0] w_sel;
      assign w_sel = w_active[in_off(NCLB, T, SELO, CLBIN, SELI, i, j) +: SELI];
      assign clb_input[i*CLBIN+j] = w_valid & w_in_tbl[w_sel];
    end
  end

  for (genvar i = 0; i < NCLB; i++) begin : g_cin
    logic [CARRY-1:0] w_src;
    if (i == 0) begin : g_first
      assign w_src = carry_in;
    end else begin : g_chain
      assign w_src = clb_cout[(i-1)*CARRY +: CARRY];
    end
    assign clb_cin[i*CARRY +: CARRY] = (w_valid && w_active[cin_off(i)]) ? w_src : '0;
  end

  assign carry_out = clb_cout[(NCLB-1)*CARRY +: CARRY];
  assign cfg_valid = w_valid;

endmodule

// File: tb/tb_cfg_connection_block.sv
// Directed bench for cfg_connection_block with a per-cycle reference model.
module tb_cfg_connection_block;
  import cfg_cb_pkg::*;

  localparam int unsigned WS     = 4;
  localparam int unsigned WD     = 8;
  localparam int unsigned NCLB   = 2;
  localparam int unsigned CLBIN  = 10;
  localparam int unsigned CLBOUT = 5;
  localparam int unsigned CARRY  = 1;
  localparam int unsigned T      = f_t(WS, WD);
  localparam int unsigned SELI   = f_seli(T);
  localparam int unsigned SELO   = f_selo(NCLB, CLBOUT);
  localparam int unsigned NB     = f_cfg_bits(NCLB, T, SELO, CLBIN, SELI);

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [T-1:0]           track_in = '0;
  logic [T-1:0]           track_out;
  logic [T-1:0]           track_oe;
  logic [NCLB*CLBOUT-1:0] clb_output = '0;
  logic [NCLB*CARRY-1:0]  clb_cout = '0;
  logic [NCLB*CLBIN-1:0]  clb_input;
  logic [NCLB*CARRY-1:0]  clb_cin;
  logic [CARRY-1:0]       carry_in = '0;
  logic [CARRY-1:0]       carry_out;
  logic                   cfg_valid;

  int n_tests = 0;
  int n_fail  = 0;

  cfg_connection_block_if cif ();

  cfg_connection_block #(
    .WS(WS), .WD(WD), .NCLB(NCLB), .CLBIN(CLBIN), .CLBOUT(CLBOUT), .CARRY(CARRY)
  ) dut (
    .clk(clk), .rst(rst), .cfg(cif),
    .track_in(track_in), .track_out(track_out), .track_oe(track_oe),
    .clb_output(clb_output), .clb_cout(clb_cout),
    .clb_input(clb_input), .clb_cin(clb_cin),
    .carry_in(carry_in), .carry_out(carry_out), .cfg_valid(cfg_valid)
  );

  always #5 clk = ~clk;

  // Reference model: the chain is a FIFO of bits, oldest bit at the far end.
  bit m_q[$];
  bit m_act[NB];
  bit m_valid;

  function automatic void model_reset();
    m_q = {};
    for (int unsigned k = 0; k < NB; k++) m_q.push_back(1'b0);
    for (int unsigned k = 0; k < NB; k++) m_act[k] = 1'b0;
    m_valid = 1'b0;
  endfunction

  initial model_reset();

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else if (cif.cen === 1'b1) begin
      if (cif.set_in === 1'b1) begin
        for (int unsigned k = 0; k < NB; k++) m_act[k] = m_q[NB-1-k];
        m_valid = 1'b1;
      end else begin
        m_q.push_back(cif.shift_in);
        void'(m_q.pop_front());
      end
    end
  end

  function automatic int unsigned fld(input int unsigned off, input int unsigned w);
    int unsigned v = 0;
    for (int unsigned b = 0; b < w; b++) if (m_act[off+b]) v = v | (32'd1 << b);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [T-1:0]           e_oe, e_out;
    logic [NCLB*CLBIN-1:0]  e_in;
    logic [NCLB*CARRY-1:0]  e_cin;
    int unsigned s;
    e_oe = '0; e_out = '0; e_in = '0; e_cin = '0;
    for (int unsigned t = 0; t < T; t++) begin
      s = fld(trk_off(NCLB, SELO, t), SELO);
      if (m_valid && s >= 1 && s <= NCLB*CLBOUT) begin
        e_oe[t]  = 1'b1;
        e_out[t] = clb_output[s-1];
      end
    end
    for (int unsigned i = 0; i < NCLB; i++)
      for (int unsigned j = 0; j < CLBIN; j++) begin
        s = fld(in_off(NCLB, T, SELO, CLBIN, SELI, i, j), SELI);
        if (m_valid && s >= 1 && s <= T) e_in[i*CLBIN+j] = track_in[s-1];
      end
    for (int unsigned i = 0; i < NCLB; i++)
      for (int unsigned c = 0; c < CARRY; c++)
        if (m_valid && m_act[cin_off(i)])
          e_cin[i*CARRY+c] = (i == 0) ? carry_in[c] : clb_cout[(i-1)*CARRY+c];
    chk("m_track_oe",  64'(track_oe),  64'(e_oe));
    chk("m_track_out", 64'(track_out), 64'(e_out));
    chk("m_clb_input", 64'(clb_input), 64'(e_in));
    chk("m_clb_cin",   64'(clb_cin),   64'(e_cin));
    chk("m_carry_out", 64'(carry_out), 64'(clb_cout[(NCLB-1)*CARRY +: CARRY]));
    chk("m_shift_out", 64'(cif.shift_out), 64'(m_q[0]));
    chk("m_cfg_valid", 64'(cfg_valid), 64'(m_valid));
  endtask

  always @(negedge clk) check_all();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NB-1:0] put(input logic [NB-1:0] img, input int unsigned off,
                                        input int unsigned w, input int unsigned val);
    logic [NB-1:0] r = img;
    for (int unsigned b = 0; b < w; b++) r[off+b] = val[b];
    return r;
  endfunction

  task automatic shift_img(input logic [NB-1:0] img);
    cif.cen = 1'b1;
    cif.set_in = 1'b0;
    for (int k = int'(NB) - 1; k >= 0; k--) begin
      cif.shift_in = img[k];
      tick();
    end
    cif.cen = 1'b0;
    cif.shift_in = 1'b0;
  endtask

  task automatic commit(input logic sh);
    cif.cen = 1'b1;
    cif.set_in = 1'b1;
    cif.shift_in = sh;
    tick();
    cif.cen = 1'b0;
    cif.set_in = 1'b0;
    cif.shift_in = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic measure(input int pause_at, input int exp_lat, input string name);
    int first = -1;
    for (int n = 1; n <= 300 && first < 0; n++) begin
      cif.cen = (pause_at > 0 && n > pause_at && n <= pause_at + 5) ? 1'b0 : 1'b1;
      cif.set_in = 1'b0;
      cif.shift_in = (n == 1);
      tick();
      if (cif.shift_out === 1'b1) first = n;
    end
    cif.cen = 1'b0;
    cif.shift_in = 1'b0;
    chk(name, 64'(first), 64'(exp_lat));
  endtask

  logic [NB-1:0] img_in, img_trk, img_cin;

  initial begin
    cif.cen = 1'b0;
    cif.set_in = 1'b0;
    cif.shift_in = 1'b0;

    // Reset held: inputs toggling must not reach any output.
    for (int k = 0; k < 4; k++) begin
      track_in   = T'($urandom);
      clb_output = (NCLB*CLBOUT)'($urandom);
      carry_in   = CARRY'($urandom);
      cif.cen    = 1'b1;
      cif.set_in = k[0];
      cif.shift_in = 1'b1;
      tick();
      chk("rst_track_oe",  64'(track_oe),  64'h0);
      chk("rst_track_out", 64'(track_out), 64'h0);
      chk("rst_clb_input", 64'(clb_input), 64'h0);
      chk("rst_clb_cin",   64'(clb_cin),   64'h0);
      chk("rst_cfg_valid", 64'(cfg_valid), 64'h0);
      chk("rst_shift_out", 64'(cif.shift_out), 64'h0);
    end
    cif.cen = 1'b0; cif.set_in = 1'b0; cif.shift_in = 1'b0;
    rst = 1'b1;

    // Shifting without a commit leaves routing off.
    cif.cen = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cif.shift_in = 1'($urandom);
      track_in = T'($urandom);
      tick();
    end
    cif.cen = 1'b0;
    chk("nocommit_track_oe",  64'(track_oe),  64'h0);
    chk("nocommit_clb_input", 64'(clb_input), 64'h0);
    chk("nocommit_valid",     64'(cfg_valid), 64'h0);

    // Chain latency, plain and with a 5-cycle cen gap.
    reset_pulse();
    measure(0, 198, "chain_latency");
    reset_pulse();
    measure(50, 203, "chain_latency_pause");

    // CLB input routing.
    reset_pulse();
    img_in = '0;
    img_in = put(img_in, in_off(NCLB, T, SELO, CLBIN, SELI, 1, 3), SELI, 5);
    img_in = put(img_in, in_off(NCLB, T, SELO, CLBIN, SELI, 0, 0), SELI, 25);
    track_in = 24'h000010;
    shift_img(img_in);
    chk("in_precommit", 64'(clb_input), 64'h0);
    commit(1'b0);
    chk("in_valid",    64'(cfg_valid), 64'h1);
    chk("in_route",    64'(clb_input), 64'h02000);
    track_in = '1; #1;
    chk("in_oor_sel",  64'(clb_input), 64'h02000);
    track_in = 24'hFFFFEF; #1;
    chk("in_route_lo", 64'(clb_input), 64'h0);

    // Track driving and glitch-free reconfiguration.
    img_trk = put('0, trk_off(NCLB, SELO, 7), SELO, 6);
    shift_img(img_trk);
    commit(1'b0);
    clb_output = 10'h020; track_in = '1; #1;
    chk("trk_oe",      64'(track_oe),  64'h80);
    chk("trk_out_hi",  64'(track_out), 64'h80);
    chk("trk_in_gone", 64'(clb_input), 64'h0);
    clb_output = 10'h3DF; #1;
    chk("trk_out_lo",  64'(track_out), 64'h0);
    clb_output = 10'h020;
    shift_img('0);
    chk("trk_hold_oe",  64'(track_oe),  64'h80);
    chk("trk_hold_out", 64'(track_out), 64'h80);
    commit(1'b0);
    chk("trk_off_oe",  64'(track_oe),  64'h0);
    chk("zero_commit_valid", 64'(cfg_valid), 64'h1);

    // cen low blocks commit; collision commit keeps staging intact.
    shift_img(img_trk);
    cif.set_in = 1'b1;
    repeat (3) tick();
    cif.set_in = 1'b0;
    chk("cen_low_commit", 64'(track_oe), 64'h0);
    commit(1'b1);
    chk("collide_oe", 64'(track_oe), 64'h80);
    commit(1'b0);
    chk("collide_stage", 64'(track_oe), 64'h80);

    // Carry chain.
    img_cin = put('0, cin_off(1), 1, 1);
    shift_img(img_cin);
    commit(1'b0);
    carry_in = 1'b1; clb_cout = 2'b01; #1;
    chk("cin_a",  64'(clb_cin),   64'h2);
    chk("cout_a", 64'(carry_out), 64'h0);
    clb_cout = 2'b10; #1;
    chk("cin_b",  64'(clb_cin),   64'h0);
    chk("cout_b", 64'(carry_out), 64'h1);
    carry_in = 1'b0; clb_cout = 2'b11; #1;
    chk("cin_c",  64'(clb_cin),   64'h2);

    // Asynchronous reset between clock edges.
    shift_img(img_trk);
    commit(1'b0);
    chk("pre_arst_oe", 64'(track_oe), 64'h80);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_track_oe",  64'(track_oe),  64'h0);
    chk("arst_track_out", 64'(track_out), 64'h0);
    chk("arst_clb_cin",   64'(clb_cin),   64'h0);
    chk("arst_valid",     64'(cfg_valid), 64'h0);
    #2;
    rst = 1'b1;
    repeat (3) tick();
    chk("post_arst_valid", 64'(cfg_valid), 64'h0);
    chk("post_arst_oe",    64'(track_oe),  64'h0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
